// File: rtl/quad_encoder_tx.sv
// rtl/quad_encoder_tx.sv - quadrature (enc_a/enc_b) step generator driven by a move command
module quad_encoder_tx #(
  parameter int STEP_DIV = 1000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  output logic             enc_a,
  output logic             enc_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       phase_q, phase_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] steps_left_q, steps_left_d;
  logic             enc_a_q, enc_a_d;
  logic             enc_b_q, enc_b_d;
  logic             done_q, done_d;

  // Gray state {A,B} for a phase; up walks 00,10,11,01 and down walks 00,01,11,10
  function automatic logic [1:0] gray_ab(input logic dir, input logic [1:0] ph);
    logic [1:0] ab;
    case (ph)
      2'd0:    ab = 2'b00;
      2'd1:    ab = dir ? 2'b10 : 2'b01;
      2'd2:    ab = 2'b11;
      default: ab = dir ? 2'b01 : 2'b10;
    endcase
    return ab;
  endfunction

  // Next-state logic: command accept in IDLE, divider/phase/step bookkeeping in RUN
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    phase_d      = phase_q;
    dir_d        = dir_q;
    steps_left_d = steps_left_q;
    enc_a_d      = enc_a_q;
    enc_b_d      = enc_b_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // Outputs rest at 00 between commands
        enc_a_d = 1'b0;
        enc_b_d = 1'b0;
        if (cmd_valid) begin
          dir_d = cmd_dir;
          if (cmd_steps == '0) begin
            // Empty move: acknowledge immediately without leaving IDLE
            done_d = 1'b1;
          end else begin
            state_d      = RUN;
            steps_left_d = cmd_steps;
            div_d        = '0;
            phase_d      = 2'd0;
          end
        end
      end

      RUN: begin
        if (div_q == DIV_LAST) begin
          div_d                = '0;
          phase_d              = phase_q + 2'd1;
          {enc_a_d, enc_b_d}   = gray_ab(dir_q, phase_q + 2'd1);
          // Wrapping from phase 3 back to 00 completes one full step
          if (phase_q == 2'd3) begin
            if (steps_left_q != '0) begin
              steps_left_d = steps_left_q - 1'b1;
            end
            if (steps_left_q <= CNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops outputs to 00, which is falling-only and so never counts
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      phase_q      <= 2'd0;
      dir_q        <= 1'b0;
      steps_left_q <= '0;
      enc_a_q      <= 1'b0;
      enc_b_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      phase_q      <= phase_d;
      dir_q        <= dir_d;
      steps_left_q <= steps_left_d;
      enc_a_q      <= enc_a_d;
      enc_b_q      <= enc_b_d;
      done_q       <= done_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign enc_a      = enc_a_q;
  assign enc_b      = enc_b_q;
  assign steps_left = steps_left_q;

endmodule

// File: tb/tb_quad_encoder_tx.sv
// tb/tb_quad_encoder_tx.sv - scoreboard bench for quad_encoder_tx
module tb_quad_encoder_tx;

  localparam int SD = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_steps = '0;
  logic          cmd_ready;
  logic          enc_a;
  logic          enc_b;
  logic          busy;
  logic          done;
  logic [CW-1:0] steps_left;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dec_count = 0;

  int         exp_cyc_q[$];
  logic [1:0] exp_enc_q[$];
  int         exp_done_q[$];

  logic [1:0] prev_enc = 2'b00;
  logic       rst_at_edge = 1'b1;

  quad_encoder_tx #(.STEP_DIV(SD), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of rising edges so far
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  function automatic logic [1:0] ref_gray(input logic dir, input int ph);
    logic [1:0] r;
    case (ph % 4)
      0:       r = 2'b00;
      1:       r = dir ? 2'b10 : 2'b01;
      2:       r = 2'b11;
      default: r = dir ? 2'b01 : 2'b10;
    endcase
    return r;
  endfunction

  // Monitor: reference decoder, single-bit rule, and scoreboard pops for enc and done
  always @(negedge clk) begin
    logic [1:0] e;
    int         ec;
    logic [1:0] ee;
    e = {enc_a, enc_b};
    if (e !== prev_enc) begin
      checks++;
      if ($countones(e ^ prev_enc) != 1 && !(rst_at_edge && e == 2'b00)) begin
        failures++;
        $display("FAIL gray_single_bit cycle=%0d got=%b prev=%b", cyc, e, prev_enc);
      end
      if (e[1] && !prev_enc[1] && !e[0] && !prev_enc[0]) dec_count++;
      if (e[0] && !prev_enc[0] && !e[1] && !prev_enc[1]) dec_count--;
      checks++;
      if (exp_cyc_q.size() == 0) begin
        failures++;
        $display("FAIL enc_unexpected cycle=%0d got=%b expected no transition", cyc, e);
      end else begin
        ec = exp_cyc_q.pop_front();
        ee = exp_enc_q.pop_front();
        if (ec != cyc || ee !== e) begin
          failures++;
          $display("FAIL enc_transition got cycle=%0d enc=%b expected cycle=%0d enc=%b", cyc, e, ec, ee);
        end
      end
      prev_enc = e;
    end
    if (done !== 1'b0) begin
      checks++;
      if (exp_done_q.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected cycle=%0d done=%b expected 0", cyc, done);
      end else begin
        ec = exp_done_q.pop_front();
        if (ec != cyc || done !== 1'b1) begin
          failures++;
          $display("FAIL done_pulse got cycle=%0d done=%b expected cycle=%0d", cyc, done, ec);
        end
      end
    end
  end

  task automatic push_cmd(input logic dir, input int n, input int t);
    for (int k = 1; k <= 4 * n; k++) begin
      exp_cyc_q.push_back(t + k * SD);
      exp_enc_q.push_back(ref_gray(dir, k));
    end
    exp_done_q.push_back(t + 4 * n * SD);
  endtask

  // Call just after a negedge; returns the accepting edge number
  task automatic issue(input logic dir, input int n, output int t);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = CW'(n);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready cycle=%0d got=%b expected 1", cyc, cmd_ready);
    end
    @(posedge clk);
    #1;
    t = cyc;
    cmd_valid = 1'b0;
    push_cmd(dir, n, t);
  endtask

  task automatic wait_until(input int target);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc < target && guard < 10000);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy !== 1'b0 || exp_cyc_q.size() != 0 || exp_done_q.size() != 0) && n < budget);
    checks++;
    if (busy !== 1'b0 || exp_cyc_q.size() != 0 || exp_done_q.size() != 0) begin
      failures++;
      $display("FAIL wait_idle_timeout busy=%b pending_enc=%0d pending_done=%0d expected idle", busy, exp_cyc_q.size(), exp_done_q.size());
    end
  endtask

  task automatic check_dec(input string name, input int c0, input int exp_delta);
    checks++;
    if (dec_count - c0 != exp_delta) begin
      failures++;
      $display("FAIL %s decoder got=%0d expected=%0d", name, dec_count - c0, exp_delta);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({enc_a, enc_b, busy, done, steps_left, cmd_ready} !== {2'b00, 1'b0, 1'b0, CW'(0), 1'b1}) begin
      failures++;
      $display("FAIL %s got enc=%b%b busy=%b done=%b steps_left=%0d ready=%b expected enc=00 busy=0 done=0 steps_left=0 ready=1",
               name, enc_a, enc_b, busy, done, steps_left, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = CW'(5);
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("reset_held");
    end
    reset     = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_idle_outputs("reset_released");
    end
  endtask

  task automatic test_up();
    int t, c0;
    @(negedge clk);
    c0 = dec_count;
    issue(1'b1, 3, t);
    for (int s = 0; s < 3; s++) begin
      wait_until(t + s * 4 * SD + 1);
      checks++;
      if (steps_left !== CW'(3 - s) || busy !== 1'b1) begin
        failures++;
        $display("FAIL up_steps_left step=%0d got=%0d busy=%b expected=%0d busy=1", s, steps_left, busy, 3 - s);
      end
    end
    wait_idle(200);
    checks++;
    if (steps_left !== CW'(0) || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL up_end got steps_left=%0d ready=%b expected 0 and 1", steps_left, cmd_ready);
    end
    check_dec("up3", c0, 3);
  endtask

  task automatic test_down();
    int t, c0;
    @(negedge clk);
    c0 = dec_count;
    issue(1'b0, 2, t);
    wait_until(t + 1);
    checks++;
    if (steps_left !== CW'(2) || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL down_start got steps_left=%0d busy=%b ready=%b expected 2 1 0", steps_left, busy, cmd_ready);
    end
    wait_idle(200);
    check_dec("down2", c0, -2);
  endtask

  task automatic test_zero();
    int t, c0;
    @(negedge clk);
    c0 = dec_count;
    issue(1'b1, 0, t);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || {enc_a, enc_b} !== 2'b00 || cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL zero_idle cycle=%0d got busy=%b enc=%b%b ready=%b expected 0 00 1", cyc, busy, enc_a, enc_b, cmd_ready);
      end
    end
    wait_idle(20);
    check_dec("zero", c0, 0);
  endtask

  task automatic test_back_to_back();
    int t1, t2, c0;
    @(negedge clk);
    c0 = dec_count;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = CW'(1);
    @(posedge clk);
    #1;
    t1 = cyc;
    push_cmd(1'b1, 1, t1);
    cmd_dir   = 1'b0;
    cmd_steps = CW'(1);
    t2 = t1 + 4 * SD + 1;
    push_cmd(1'b0, 1, t2);
    wait_until(t1 + 2);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_hold got ready=%b busy=%b expected 0 1", cmd_ready, busy);
    end
    wait_until(t1 + 4 * SD);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || {enc_a, enc_b} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_done_cycle got ready=%b busy=%b enc=%b%b expected 1 0 00", cmd_ready, busy, enc_a, enc_b);
    end
    wait_until(t2);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_accept got ready=%b busy=%b expected 0 1", cmd_ready, busy);
    end
    cmd_valid = 1'b0;
    wait_idle(200);
    check_dec("back_to_back", c0, 0);
  endtask

  task automatic test_max();
    int t, c0;
    @(negedge clk);
    c0 = dec_count;
    issue(1'b1, (1 << CW) - 1, t);
    wait_until(t + 1);
    checks++;
    if (steps_left !== {CW{1'b1}}) begin
      failures++;
      $display("FAIL max_start got steps_left=%0d expected=%0d", steps_left, (1 << CW) - 1);
    end
    wait_idle(((1 << CW) - 1) * 4 * SD + 100);
    checks++;
    if (steps_left !== CW'(0)) begin
      failures++;
      $display("FAIL max_end got steps_left=%0d expected 0", steps_left);
    end
    check_dec("max", c0, (1 << CW) - 1);
  endtask

  task automatic test_reset_mid_run();
    int t, t2, c0;
    @(negedge clk);
    c0 = dec_count;
    issue(1'b1, 5, t);
    wait_until(t + 6 * SD + 1);
    checks++;
    if ({enc_a, enc_b} !== 2'b11 || steps_left !== CW'(4)) begin
      failures++;
      $display("FAIL midrun_pre got enc=%b%b steps_left=%0d expected 11 4", enc_a, enc_b, steps_left);
    end
    exp_cyc_q.delete();
    exp_enc_q.delete();
    exp_done_q.delete();
    exp_cyc_q.push_back(cyc + 1);
    exp_enc_q.push_back(2'b00);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrun_snap");
    check_dec("midrun_reset", c0, 2);
    reset     = 1'b0;
    issue(1'b0, 1, t2);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midrun_reaccept got busy=%b expected 1", busy);
    end
    wait_idle(200);
    check_dec("midrun_total", c0, 1);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog cycle=%0d expected completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_up();
    test_down();
    test_zero();
    test_back_to_back();
    test_max();
    test_reset_mid_run();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_cyc_q.size() != 0 || exp_done_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got pending_enc=%0d pending_done=%0d expected 0 0", exp_cyc_q.size(), exp_done_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
